// File: rtl/relay_reg_bank.sv
// Bank of NUM_REGS relay data registers with a settle-delayed load FSM,
// a registered select-onto-bus path with conflict detection, and lamp outputs.
module relay_reg_bank #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_REGS      = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  localparam int unsigned IDX_W        = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_req,
  input  logic [IDX_W-1:0]    ld_idx,
  input  logic                ld_src,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [WIDTH-1:0]    bus_in,
  input  logic [NUM_REGS-1:0] sel,
  output logic [WIDTH-1:0]    bus_out,
  output logic                bus_oe,
  output logic                ld_busy,
  output logic                ld_done,
  output logic                sel_conflict,
  output logic [NUM_REGS-1:0] led_load,
  output logic [NUM_REGS-1:0] led_sel
);

  typedef enum logic [1:0] {StIdle, StSettle, StCommit} state_e;

  localparam logic [3:0]          SettleCnt = 4'(SETTLE_CYCLES);
  localparam logic [NUM_REGS-1:0] OneSel    = NUM_REGS'(1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    regs_q [NUM_REGS];

  logic [WIDTH-1:0]    bus_out_q;
  logic                bus_oe_q;
  logic                sel_conflict_q;
  logic [NUM_REGS-1:0] led_sel_q;

  logic [WIDTH-1:0]    sel_data;
  logic                sel_any;
  logic                sel_multi;

  // Load FSM; operand and index are captured at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (ld_req) begin
            idx_q   <= ld_idx;
            data_q  <= ld_src ? bus_in : alu_result;
            cnt_q   <= SettleCnt;
            state_q <= (SETTLE_CYCLES == 0) ? StCommit : StSettle;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          // An index with no matching register simply writes nothing.
          for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              regs_q[i] <= data_q;
            end
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) begin
        sel_data = sel_data | regs_q[i];
      end
    end
    sel_any   = |sel;
    sel_multi = |(sel & (sel - OneSel));
  end

  // Select path reads regs_q before any same-edge commit lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_out_q      <= '0;
      bus_oe_q       <= 1'b0;
      sel_conflict_q <= 1'b0;
      led_sel_q      <= '0;
    end else begin
      bus_oe_q       <= sel_any && !sel_multi;
      bus_out_q      <= (sel_any && !sel_multi) ? sel_data : '0;
      sel_conflict_q <= sel_multi;
      led_sel_q      <= sel;
    end
  end

  always_comb begin
    led_load = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ld_busy && (idx_q == IDX_W'(i))) begin
        led_load[i] = 1'b1;
      end
    end
  end

  assign ld_busy      = (state_q != StIdle);
  assign ld_done      = (state_q == StCommit);
  assign bus_out      = bus_out_q;
  assign bus_oe       = bus_oe_q;
  assign sel_conflict = sel_conflict_q;
  assign led_sel      = led_sel_q;

endmodule

// File: tb/tb_relay_reg_bank.sv
// Directed bench for relay_reg_bank: vector table for the default build plus
// hand sequences for reset mid-load and a zero-settle build.
module tb_relay_reg_bank;

  logic       clk;
  logic       rst_n, ld_req, ld_src;
  logic [1:0] ld_idx;
  logic [7:0] alu_result, bus_in;
  logic [3:0] sel;
  logic [7:0] bus_out;
  logic       bus_oe, ld_busy, ld_done, sel_conflict;
  logic [3:0] led_load, led_sel;

  logic       s0_rst_n, s0_ld_req, s0_ld_src;
  logic [1:0] s0_ld_idx;
  logic [7:0] s0_alu_result, s0_bus_in;
  logic [3:0] s0_sel;
  logic [7:0] s0_bus_out;
  logic       s0_bus_oe, s0_ld_busy, s0_ld_done, s0_sel_conflict;
  logic [3:0] s0_led_load, s0_led_sel;

  int n_tests = 0;
  int n_fail  = 0;

  relay_reg_bank #(.WIDTH(8), .NUM_REGS(4), .SETTLE_CYCLES(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_idx(ld_idx), .ld_src(ld_src),
    .alu_result(alu_result), .bus_in(bus_in), .sel(sel), .bus_out(bus_out),
    .bus_oe(bus_oe), .ld_busy(ld_busy), .ld_done(ld_done), .sel_conflict(sel_conflict),
    .led_load(led_load), .led_sel(led_sel)
  );

  relay_reg_bank #(.WIDTH(8), .NUM_REGS(4), .SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .rst_n(s0_rst_n), .ld_req(s0_ld_req), .ld_idx(s0_ld_idx),
    .ld_src(s0_ld_src), .alu_result(s0_alu_result), .bus_in(s0_bus_in), .sel(s0_sel),
    .bus_out(s0_bus_out), .bus_oe(s0_bus_oe), .ld_busy(s0_ld_busy), .ld_done(s0_ld_done),
    .sel_conflict(s0_sel_conflict), .led_load(s0_led_load), .led_sel(s0_led_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, ld_req;
    logic [1:0] ld_idx;
    logic       ld_src;
    logic [7:0] alu, bus;
    logic [3:0] sel;
    logic [7:0] e_out;
    logic       e_oe, e_busy, e_done, e_conf;
    logic [3:0] e_ll, e_ls;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic q, logic [1:0] ix, logic sr, logic [7:0] a,
                             logic [7:0] b, logic [3:0] s, logic [7:0] eo, logic eoe,
                             logic eb, logic ed, logic ec, logic [3:0] ell, logic [3:0] els);
    vec_t t;
    t.rst_n = r;  t.ld_req = q; t.ld_idx = ix; t.ld_src = sr; t.alu = a; t.bus = b;
    t.sel = s;    t.e_out = eo; t.e_oe = eoe;  t.e_busy = eb; t.e_done = ed;
    t.e_conf = ec; t.e_ll = ell; t.e_ls = els;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_main();
    return {12'd0, bus_out, bus_oe, ld_busy, ld_done, sel_conflict, led_load, led_sel};
  endfunction

  initial begin
    rst_n = 1'b0; ld_req = 1'b0; ld_idx = '0; ld_src = 1'b0;
    alu_result = '0; bus_in = '0; sel = '0;
    s0_rst_n = 1'b0; s0_ld_req = 1'b0; s0_ld_idx = '0; s0_ld_src = 1'b0;
    s0_alu_result = '0; s0_bus_in = '0; s0_sel = '0;

    // Each row: inputs applied before an edge, expected outputs just after it.
    vecs.push_back(v(0, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 8'h00, 0, 0, 0, 0, 4'b0000, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 8'h00, 1, 0, 0, 0, 4'b0000, 4'b0001));
    vecs.push_back(v(1, 1, 2, 0, 8'hA5, 8'h00, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b0100, 4'b0000));
    vecs.push_back(v(1, 1, 1, 1, 8'hFF, 8'h3C, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b0100, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'hFF, 8'h00, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b0100, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'hFF, 8'h00, 4'b0000, 8'h00, 0, 1, 1, 0, 4'b0100, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0100, 8'h00, 1, 0, 0, 0, 4'b0000, 4'b0100));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0100, 8'hA5, 1, 0, 0, 0, 4'b0000, 4'b0100));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0010, 8'h00, 1, 0, 0, 0, 4'b0000, 4'b0010));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0101, 8'h00, 0, 0, 0, 1, 4'b0000, 4'b0101));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 8'h00, 1, 0, 0, 0, 4'b0000, 4'b0001));
    vecs.push_back(v(1, 1, 3, 1, 8'h00, 8'h77, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b1000, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b1000, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b1000, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 1, 1, 0, 4'b1000, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b1000, 8'h00, 1, 0, 0, 0, 4'b0000, 4'b1000));
    vecs.push_back(v(1, 1, 0, 0, 8'h5A, 8'h00, 4'b1000, 8'h77, 1, 1, 0, 0, 4'b0001, 4'b1000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b0001, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 1, 0, 0, 4'b0001, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 1, 1, 0, 4'b0001, 4'b0000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 8'h00, 1, 0, 0, 0, 4'b0000, 4'b0001));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0001, 8'h5A, 1, 0, 0, 0, 4'b0000, 4'b0001));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0100, 8'hA5, 1, 0, 0, 0, 4'b0000, 4'b0100));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b1000, 8'h77, 1, 0, 0, 0, 4'b0000, 4'b1000));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b1110, 8'h00, 0, 0, 0, 1, 4'b0000, 4'b1110));
    vecs.push_back(v(1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 8'h00, 0, 0, 0, 0, 4'b0000, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; ld_req = vecs[i].ld_req; ld_idx = vecs[i].ld_idx;
      ld_src = vecs[i].ld_src; alu_result = vecs[i].alu; bus_in = vecs[i].bus;
      sel = vecs[i].sel;
      step();
      check($sformatf("vec%0d", i), pack_main(),
            {12'd0, vecs[i].e_out, vecs[i].e_oe, vecs[i].e_busy, vecs[i].e_done,
             vecs[i].e_conf, vecs[i].e_ll, vecs[i].e_ls});
    end

    // Reset in SETTLE abandons the load to reg0.
    ld_req = 1'b1; ld_idx = 2'd0; ld_src = 1'b0; alu_result = 8'h11; sel = 4'b0000;
    step();
    ld_req = 1'b0;
    step();
    check("midload_busy", {31'd0, ld_busy}, 32'd1);
    rst_n = 1'b0;
    step();
    check("rst_busy", {28'd0, ld_busy, ld_done, bus_oe, sel_conflict}, 32'd0);
    check("rst_leds", {24'd0, led_load, led_sel}, 32'd0);
    rst_n = 1'b1; sel = 4'b0001;
    begin
      int done_seen;
      done_seen = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        if (ld_done) done_seen++;
      end
      check("rst_no_commit", done_seen, 0);
    end
    check("rst_reg0", {23'd0, bus_oe, bus_out}, {23'd0, 1'b1, 8'h00});
    sel = 4'b0100;
    step();
    check("rst_reg2", {23'd0, bus_oe, bus_out}, {23'd0, 1'b1, 8'h00});

    // Zero-settle build: commit one cycle after accept.
    step();
    s0_rst_n = 1'b1; s0_ld_req = 1'b1; s0_ld_idx = 2'd1; s0_alu_result = 8'h42;
    step();
    check("s0_accept", {26'd0, s0_ld_busy, s0_ld_done, s0_led_load}, {26'd0, 2'b11, 4'b0010});
    s0_ld_req = 1'b0; s0_sel = 4'b0010;
    step();
    check("s0_commit", {22'd0, s0_ld_busy, s0_ld_done, s0_bus_oe, s0_bus_out},
          {22'd0, 1'b0, 1'b0, 1'b1, 8'h00});
    step();
    check("s0_readback", {23'd0, s0_bus_oe, s0_bus_out}, {23'd0, 1'b1, 8'h42});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
